// File: rtl/counter_sequencer.sv
// Sequencer that loads the cascaded preset counter and runs it for a
// programmed number of Co rounds, with pause, abort and a done pulse.
// Ports: clk, clrn (async active-low) | start, pause, abort, co,
//   cfg_da/cfg_db/cfg_rounds in | load, en, Da, Db, busy, done,
//   rounds_done out. All outputs come straight from flops.
module counter_sequencer #(
  parameter int WA = 4,
  parameter int WB = 3,
  parameter int WR = 4
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic          co,
  input  logic [WA-1:0] cfg_da,
  input  logic [WB-1:0] cfg_db,
  input  logic [WR-1:0] cfg_rounds,
  output logic          load,
  output logic          en,
  output logic [WA-1:0] Da,
  output logic [WB-1:0] Db,
  output logic          busy,
  output logic          done,
  output logic [WR-1:0] rounds_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [WA-1:0] da_q, da_d;
  logic [WB-1:0] db_q, db_d;
  logic [WR-1:0] left_q, left_d;
  logic [WR-1:0] rdone_q, rdone_d;
  logic          load_q, load_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    da_d    = da_q;
    db_d    = db_q;
    left_d  = left_q;
    rdone_d = rdone_q;
    unique case (state_q)
      S_IDLE: begin
        if (!abort && start &&
            cfg_rounds != '0) begin
          da_d    = cfg_da;
          db_d    = cfg_db;
          left_d  = cfg_rounds;
          rdone_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (co) begin
          // count first; a final Co beats pause
          rdone_d = rdone_q + WR'(1);
          left_d  = left_q - WR'(1);
          if (left_q == WR'(1))
            state_d = S_DONE;
          else if (pause)
            state_d = S_PAUSE;
        end else if (pause) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (abort)
          state_d = S_IDLE;
        else if (!pause)
          state_d = S_RUN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // outputs registered from the next state so they track state_q
  always_comb begin
    load_d = (state_d == S_LOAD);
    en_d   = (state_d == S_LOAD) ||
             (state_d == S_RUN);
    busy_d = (state_d == S_LOAD) ||
             (state_d == S_RUN)  ||
             (state_d == S_PAUSE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      da_q    <= '0;
      db_q    <= '0;
      left_q  <= '0;
      rdone_q <= '0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      da_q    <= da_d;
      db_q    <= db_d;
      left_q  <= left_d;
      rdone_q <= rdone_d;
      load_q  <= load_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign load        = load_q;
  assign en          = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign Da          = da_q;
  assign Db          = db_q;
  assign rounds_done = rdone_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer.
// Ctl vector below is {load, en, busy, done}.
module tb_counter_sequencer;

  logic       clk;
  logic       clrn;
  logic       start;
  logic       pause;
  logic       abort;
  logic       co;
  logic [3:0] cfg_da;
  logic [2:0] cfg_db;
  logic [3:0] cfg_rounds;
  logic       load;
  logic       en;
  logic [3:0] Da;
  logic [2:0] Db;
  logic       busy;
  logic       done;
  logic [3:0] rounds_done;

  int vectors;
  int miscompares;

  counter_sequencer #(.WA(4), .WB(3), .WR(4)) dut (
    .clk(clk), .clrn(clrn), .start(start), .pause(pause),
    .abort(abort), .co(co), .cfg_da(cfg_da), .cfg_db(cfg_db),
    .cfg_rounds(cfg_rounds), .load(load), .en(en), .Da(Da),
    .Db(Db), .busy(busy), .done(done), .rounds_done(rounds_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string nm, input logic [3:0] exp);
    vectors++;
    if ({load, en, busy, done} !== exp) begin
      miscompares++;
      $display("FAIL %s ctl got %b exp %b", nm,
               {load, en, busy, done}, exp);
    end
  endtask

  task automatic chk_rd(input string nm, input logic [3:0] exp);
    vectors++;
    if (rounds_done !== exp) begin
      miscompares++;
      $display("FAIL %s rounds_done got %0d exp %0d", nm,
               rounds_done, exp);
    end
  endtask

  task automatic chk_pre(input string nm,
                         input logic [3:0] ea,
                         input logic [2:0] eb);
    vectors++;
    if ({Da, Db} !== {ea, eb}) begin
      miscompares++;
      $display("FAIL %s Da/Db got %0d/%0d exp %0d/%0d", nm,
               Da, Db, ea, eb);
    end
  endtask

  task automatic go(input logic [3:0] a, input logic [2:0] b,
                    input logic [3:0] r);
    cfg_da = a; cfg_db = b; cfg_rounds = r;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    co = 1'b0; cfg_da = '0; cfg_db = '0; cfg_rounds = '0;
    #2;
    clrn = 1'b0;
    start = 1'b1; cfg_rounds = 4'd3; cfg_da = 4'd9;
    for (int i = 0; i < 4; i++) begin
      co = i[0]; pause = i[1];
      tick();
    end
    chk_ctl("reset_ctl", 4'b0000);
    chk_pre("reset_pre", 4'd0, 3'd0);
    chk_rd("reset_rd", 4'd0);
    start = 1'b0; co = 1'b0; pause = 1'b0;
    #2;
    clrn = 1'b1;
    tick(); tick(); tick();
    chk_ctl("reset_idle", 4'b0000);
  endtask

  task automatic test_basic();
    go(4'd7, 3'd5, 4'd3);
    chk_ctl("basic_load", 4'b1110);
    chk_pre("basic_pre", 4'd7, 3'd5);
    chk_rd("basic_rd0", 4'd0);
    tick();
    chk_ctl("basic_run", 4'b0110);
    co = 1'b1; tick(); co = 1'b0;
    chk_rd("basic_rd1", 4'd1);
    tick();
    co = 1'b1; tick(); co = 1'b0;
    chk_rd("basic_rd2", 4'd2);
    chk_ctl("basic_run2", 4'b0110);
    tick();
    co = 1'b1; tick(); co = 1'b0;
    chk_rd("basic_rd3", 4'd3);
    chk_ctl("basic_done", 4'b0001);
    tick();
    chk_ctl("basic_idle", 4'b0000);
    chk_pre("basic_hold", 4'd7, 3'd5);
  endtask

  task automatic test_pause();
    go(4'd3, 3'd2, 4'd3);
    tick();
    pause = 1'b1;
    tick();
    chk_ctl("pause_enter", 4'b0010);
    co = 1'b1;
    tick(); tick(); tick();
    chk_ctl("pause_hold", 4'b0010);
    chk_rd("pause_rd", 4'd0);
    co = 1'b0; pause = 1'b0;
    tick();
    chk_ctl("pause_resume", 4'b0110);
    co = 1'b1; tick(); co = 1'b0;
    chk_rd("pause_count", 4'd1);
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_simultaneous();
    go(4'd1, 3'd1, 4'd2);
    tick();
    co = 1'b1; pause = 1'b1;
    tick();
    chk_rd("simul_rd1", 4'd1);
    chk_ctl("simul_pause", 4'b0010);
    co = 1'b0; pause = 1'b0;
    tick();
    chk_ctl("simul_run", 4'b0110);
    co = 1'b1; pause = 1'b1;
    tick();
    chk_rd("simul_rd2", 4'd2);
    chk_ctl("simul_done", 4'b0001);
    co = 1'b0; pause = 1'b0;
    tick();
    chk_ctl("simul_idle", 4'b0000);
  endtask

  task automatic test_abort_ignore();
    go(4'd7, 3'd5, 4'd3);
    tick();
    co = 1'b1; tick(); co = 1'b0;
    pause = 1'b1; tick();
    chk_ctl("abort_in_pause", 4'b0010);
    abort = 1'b1; tick(); abort = 1'b0; pause = 1'b0;
    chk_ctl("abort_idle", 4'b0000);
    chk_rd("abort_rd_kept", 4'd1);
    tick();
    chk_ctl("abort_no_done", 4'b0000);
    go(4'd4, 3'd4, 4'd0);
    chk_ctl("zero_rounds", 4'b0000);
    chk_pre("zero_no_latch", 4'd7, 3'd5);
    chk_rd("zero_rd_kept", 4'd1);
    go(4'd7, 3'd5, 4'd3);
    chk_rd("restart_clr", 4'd0);
    cfg_da = 4'd2; cfg_db = 3'd1; cfg_rounds = 4'd5;
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk_pre("busy_start", 4'd7, 3'd5);
    chk_ctl("busy_run", 4'b0110);
    co = 1'b1; abort = 1'b1;
    tick();
    co = 1'b0; abort = 1'b0;
    chk_rd("abort_co_drop", 4'd0);
    chk_ctl("abort_run", 4'b0000);
  endtask

  task automatic test_async_reset();
    go(4'd6, 3'd3, 4'd4);
    tick();
    co = 1'b1; tick(); co = 1'b0;
    chk_ctl("async_pre", 4'b0110);
    #2;
    clrn = 1'b0;
    #1;
    chk_ctl("async_ctl", 4'b0000);
    chk_pre("async_pre0", 4'd0, 3'd0);
    chk_rd("async_rd0", 4'd0);
    clrn = 1'b1;
    tick(); tick();
    chk_ctl("async_idle", 4'b0000);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_pause();
    test_simultaneous();
    test_abort_ignore();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Moore-style controller that runs the cascaded preset counter (4-bit A stage, 3-bit B stage, carry-out Co) through a programmed number of full carry rounds. It latches a configuration on a start command and drives the counter's load/enable and preset data. It counts Co pulses, supports pause/resume and abort, and reports completion. It sits between the top-level control inputs and the counter datapath, which it owns exclusively.

## Interface
- WA, 4, width of counter stage A preset (Da)
- WB, 3, width of counter stage B preset (Db)
- WR, 4, width of round count and round counter
- clk  in  1  rising-edge clock
- clrn  in  1  reset; one clock, asynchronous, active-low
- start  in  1  begin a run; sampled only in IDLE
- pause  in  1  level; hold counter while high (RUN/PAUSE only)
- abort  in  1  level; return to IDLE, highest priority
- co  in  1  carry-out from the counter
- cfg_da  in  WA  preset for stage A
- cfg_db  in  WB  preset for stage B
- cfg_rounds  in  WR  number of Co pulses to run; 0 is invalid
- load  out  1  counter synchronous load strobe
- en  out  1  counter count enable
- Da  out  WA  latched preset A
- Db  out  WB  latched preset B
- busy  out  1  high in LOAD, RUN, PAUSE
- done  out  1  one-cycle completion pulse
- rounds_done  out  WR  Co pulses counted in the current or last run

## Operation
- States: IDLE, LOAD, RUN, PAUSE, DONE. All outputs are registered or decoded from the state register; there is no combinational input-to-output path.
- IDLE: load=0, en=0, busy=0. start=1 with cfg_rounds≠0 latches cfg_da→Da, cfg_db→Db, cfg_rounds→rounds_left, clears rounds_done, and moves to LOAD. start with cfg_rounds=0 is ignored and the state stays IDLE.
- LOAD: exactly one cycle with load=1, en=1. Unconditionally moves to RUN, unless abort.
- RUN: en=1, load=0. On co=1, rounds_done +1 and rounds_left −1. If co=1 and rounds_left==1, go to DONE. Otherwise pause=1 moves to PAUSE.
- PAUSE: en=0. co is ignored. pause=0 returns to RUN.
- DONE: one cycle with done=1, en=0, busy=0, then IDLE.
- abort=1 in LOAD/RUN/PAUSE/DONE moves to IDLE on the next edge. Any co in that cycle is not counted. rounds_done holds its value.
- co=1 is counted only in RUN. It is ignored in IDLE, LOAD, PAUSE and DONE.
- Same-cycle co=1 and pause=1 in RUN: co is counted first. If that Co was the final round, DONE wins over PAUSE.
- start while busy is ignored, and configuration inputs are not re-latched.
- Da/Db/rounds_done hold until the next accepted start. rounds_done never wraps, because rounds_left bounds it to cfg_rounds ≤ 2^WR−1.

## Timing
- Reset (clrn=0, async): state=IDLE, load=0, en=0, busy=0, done=0, Da=0, Db=0, rounds_done=0, rounds_left=0.
- Reset mid-run forces the reset values immediately, independent of clk.
- start sampled at edge k produces LOAD during cycle k→k+1 (load=1). The counter loads at edge k+1, and RUN begins after k+1.
- Final co sampled at edge m produces done=1 for cycle m→m+1, then IDLE after m+1.
- pause sampled at edge p produces en=0 from p. Deasserting pause sampled at edge r produces en=1 from r.
- Latency from start to first counting edge: 2 clocks.

## Test plan
- Reset: hold clrn=0 with start=1 and other inputs toggling -> all outputs 0. Then release clrn and hold start=0 -> state stays IDLE.
- Basic run: cfg_da=7, cfg_db=5, cfg_rounds=3, pulse start -> load=1 for exactly 1 cycle with Da=7, Db=5. Then apply three co pulses -> rounds_done reaches 3, done pulses once, and en=0 in the cycle after the third co.
- Pause: while in RUN hold pause=1 for 4 cycles and assert co during them -> en=0, rounds_done unchanged. After pause=0, en=1 returns on the next edge.
- Simultaneous: with cfg_rounds=2 and rounds_done=1, assert co=1 and pause=1 together -> DONE (done=1) and no PAUSE entry. Repeat with rounds_done=0 -> rounds_done=1 and state PAUSE.
- Abort/ignore: abort in PAUSE -> IDLE next cycle, en=0, done never asserted, rounds_done kept. cfg_rounds=0 with start -> busy stays 0. start while busy with new cfg_da=2 -> Da stays 7.
- Async reset mid-RUN: drop clrn between edges -> en and busy fall without a clock edge. Release clrn -> IDLE.
